// File: rtl/reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reduce_pkg
// Purpose  : Shared definitions for the reduction-core stages: packet and
//            data widths, header field offsets, op codes, the issue/collect
//            delay-line entry type and a header op-field accessor.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reduce_pkg;

  localparam int PKT_W  = 64;
  localparam int DATA_W = 32;
  localparam int HDR_W  = PKT_W - DATA_W;

  // Header field offsets, relative to packet bits 63:32.
  localparam int HDR_VALID_BIT     = 31;
  localparam int HDR_REDUCTION_BIT = 30;
  localparam int HDR_OP_LSB        = 0;
  localparam int OP_W              = 5;

  localparam logic [OP_W-1:0] OP_MAX = 5'd2;
  localparam logic [OP_W-1:0] OP_MIN = 5'd3;

  // One stage of the header delay line that shadows the compute pipeline.
  //   op_sel : 0 = take res_max, 1 = take res_min
  //   err    : op unsupported, payload comes from a_copy instead
  typedef struct packed {
    logic              tag_valid;
    logic [HDR_W-1:0]  hdr;
    logic              op_sel;
    logic              err;
    logic [DATA_W-1:0] a_copy;
  } dl_entry_t;

  function automatic logic [OP_W-1:0] hdr_op(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_OP_LSB +: OP_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered pointers and occupancy count.
//            Writes when full and reads when empty are ignored. The read
//            data port always shows the entry at the read pointer.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            wr_en_i       - push wdata_i
//            wdata_i       - write data
//            rd_en_i       - pop the head entry
//            rdata_o       - head entry (undefined content when empty)
//            empty_o       - no entries stored
//            full_o        - DEPTH entries stored
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign w_push  = wr_en_i && !full_o;
  assign w_pop   = rd_en_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= ptr_inc(wptr_q);
      if (w_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/reduce_minmax_collect.sv
`default_nettype none
// ============================================================================
// Module   : reduce_minmax_collect
// Purpose  : Issue-and-collect stage around the fixed-latency max/min
//            compute pipeline. Accepts {hdr, a, b}, issues a/b to the
//            pipeline, carries the header in a matching delay line, selects
//            max or min on return and queues the 64-bit packet in an output
//            FIFO. A credit counter reserves FIFO space at issue so the
//            non-stallable pipeline can always be written back.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid/in_ready    - input handshake
//            in_hdr, in_a, in_b   - header (packet bits 63:32) and operands
//            cmp_go, cmp_a, cmp_b - registered issue to compute pipeline
//            res_max, res_min     - pipeline results, LAT cycles after cmp_go
//            out_valid/out_ready  - output handshake
//            out_pkt, out_err     - FIFO head {hdr, payload}, unsupported-op
// Revision : 1.0 - initial release
// ============================================================================
module reduce_minmax_collect
  import reduce_pkg::*;
#(
  parameter int LAT   = 13,
  parameter int DEPTH = 16   // must be >= LAT+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HDR_W-1:0]  in_hdr,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              cmp_go,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic [DATA_W-1:0] res_max,
  input  logic [DATA_W-1:0] res_min,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_pkt,
  output logic              out_err
);

  localparam int ENTRY_W = PKT_W + 1;              // {err, hdr, payload}
  localparam int USED_W  = $clog2(DEPTH + 1);
  localparam logic [USED_W-1:0] USED_MAX = USED_W'(DEPTH);

  logic [USED_W-1:0]  used_q;
  logic [USED_W-1:0]  used_d;
  logic               w_accept;
  logic               w_pop;
  logic [OP_W-1:0]    w_op;
  dl_entry_t          w_stage0;
  dl_entry_t          dl_q [LAT+1];
  dl_entry_t          w_last;
  logic               w_res_valid;
  logic [DATA_W-1:0]  w_payload;
  logic               cmp_go_q;
  logic [DATA_W-1:0]  cmp_a_q;
  logic [DATA_W-1:0]  cmp_b_q;
  logic               w_fifo_wr;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [ENTRY_W-1:0] w_fifo_wdata;
  logic [ENTRY_W-1:0] w_fifo_rdata;

  // --------------------------------------------------------------------------
  // Credit counter: in-flight work plus FIFO occupancy. in_ready depends only
  // on the registered count, so a pop frees a credit one cycle later.
  // --------------------------------------------------------------------------
  assign in_ready  = !rst && (used_q < USED_MAX);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = !w_fifo_empty;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    used_d = used_q;
    case ({w_accept, w_pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) used_q <= '0;
    else     used_q <= used_d;
  end

  // --------------------------------------------------------------------------
  // Issue registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_go_q <= 1'b0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
    end else begin
      cmp_go_q <= w_accept;
      if (w_accept) begin
        cmp_a_q <= in_a;
        cmp_b_q <= in_b;
      end
    end
  end

  assign cmp_go = cmp_go_q;
  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;

  // --------------------------------------------------------------------------
  // Header delay line. Stage 0 loads on the accept edge; stage LAT is
  // presented during the cycle in which res_* is valid, so both are sampled
  // on the same edge. Unsupported ops keep a copy of in_a as their payload.
  // --------------------------------------------------------------------------
  always_comb begin
    w_stage0 = '0;
    w_op     = hdr_op(in_hdr);
    if (w_accept) begin
      w_stage0.tag_valid = 1'b1;
      w_stage0.hdr       = in_hdr;
      w_stage0.op_sel    = (w_op == OP_MIN);
      w_stage0.err       = (w_op != OP_MAX) && (w_op != OP_MIN);
      w_stage0.a_copy    = in_a;
    end
  end

  // Reset clears every tag so results of pre-reset work are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= w_stage0;
      for (int i = 1; i <= LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign w_last      = dl_q[LAT];
  assign w_res_valid = w_last.tag_valid;

  always_comb begin
    w_payload = res_max;
    if (w_last.err)         w_payload = w_last.a_copy;
    else if (w_last.op_sel) w_payload = res_min;
  end

  // --------------------------------------------------------------------------
  // Output FIFO. Credits guarantee space at write time; the full term only
  // keeps the FIFO state consistent should that ever be violated.
  // --------------------------------------------------------------------------
  assign w_fifo_wr    = w_res_valid && !w_fifo_full;
  assign w_fifo_wdata = {w_last.err, w_last.hdr, w_payload};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (w_fifo_wr),
    .wdata_i (w_fifo_wdata),
    .rd_en_i (w_pop),
    .rdata_o (w_fifo_rdata),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  // Head is forced to zero when empty so stale storage never shows.
  assign out_pkt = w_fifo_empty ? '0   : w_fifo_rdata[PKT_W-1:0];
  assign out_err = w_fifo_empty ? 1'b0 : w_fifo_rdata[PKT_W];

endmodule
`default_nettype wire
